// File: rtl/vx_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// vx_mem_responder_pkg
//
// Shared constants and helpers for the on-chip memory responder.
// Default widths for the cluster L2MEM port; instances may override them.
// -----------------------------------------------------------------------------
package vx_mem_responder_pkg;

  localparam int unsigned L2MEM_DATA_W = 512;
  localparam int unsigned L2MEM_ADDR_W = 26;
  localparam int unsigned L2MEM_TAG_W  = 8;

  // Width of a counter/pointer that must represent 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vx_mem_rsp_pipe.sv
// -----------------------------------------------------------------------------
// vx_mem_rsp_pipe
//
// Response path of the memory responder.  It has two parts:
// - a LATENCY-stage, valid-tagged delay line;
// - a DEPTH-entry first-word-fall-through FIFO behind the delay line.
// When the FIFO is empty and the consumer is ready, the entry leaving the
// delay line is handed out directly.  A response therefore appears exactly
// LATENCY cycles after it enters, unless the queue is backed up.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset. Reset clears valids
//                  and pointers only; payload storage is not reset.
//   in_valid_i   - push a payload into the delay line this cycle
//   in_data_i    - payload
//   out_valid_o  - response available
//   out_data_o   - response payload; held stable while out_valid_o && !out_ready_i
//   out_ready_i  - consumer accepts the response
//   empty_o      - FIFO holds no entries
//   full_o       - FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module vx_mem_rsp_pipe
  import vx_mem_responder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = credit_width(DEPTH);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];
  logic [WIDTH-1:0]   fifo_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;

  logic             line_vld;
  logic [WIDTH-1:0] line_dat;
  logic             empty, full;
  logic             bypass, push, pop_fifo;

  // Delay line: valids reset, payload free-running
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= in_data_i;
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign line_vld = vld_q[LATENCY-1];
  assign line_dat = dat_q[LATENCY-1];

  // Pointers carry one extra wrap bit, which distinguishes full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // An entry leaving the delay line skips the FIFO only when nothing is
  // queued ahead of it and the consumer takes it this cycle.  Otherwise it
  // is parked in the FIFO.  This keeps the order and keeps out_data_o stable.
  assign bypass   = empty && line_vld && out_ready_i;
  assign push     = line_vld && !bypass;
  assign pop_fifo = !empty && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= line_dat;
  end

  assign out_valid_o = !empty || line_vld;
  assign out_data_o  = empty ? line_dat : fifo_q[rd_ptr_q[AW-1:0]];
  assign empty_o     = empty;
  assign full_o      = full;

  // Upstream credit limiting must make this unreachable
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full)) else $error("vx_mem_rsp_pipe: push into full FIFO");
    end
  end

endmodule

// File: rtl/vx_mem_responder.sv
// -----------------------------------------------------------------------------
// vx_mem_responder
//
// Memory-side endpoint for the cluster L2MEM port.  It is backed by a local
// byte-enabled RAM, one line per entry.  Writes update the RAM and produce
// no response.  Reads return {data, tag} after a fixed LATENCY, in
// acceptance order.  At most RSPQ_SIZE reads are outstanding at a time.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset. Reset does not
//                     clear the RAM contents.
//   mem_req_*       - request channel (valid/ready, rw: 1=write, byteen,
//                     line addr, data, tag)
//   mem_rsp_*       - read response channel (valid/ready, data, tag)
//   busy            - at least one read is outstanding
// -----------------------------------------------------------------------------
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = L2MEM_DATA_W,
  parameter int ADDR_WIDTH     = L2MEM_ADDR_W,
  parameter int TAG_WIDTH      = L2MEM_TAG_W,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int LATENCY        = 4,
  parameter int RSPQ_SIZE      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int RSP_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int CNT_W     = credit_width(RSPQ_SIZE);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(RSPQ_SIZE);

  logic [CNT_W-1:0]          credits_q, credits_d;
  logic                      req_fire, rd_fire, wr_fire, rsp_fire;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic [DATA_WIDTH-1:0]     ram_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]     rd_data;
  logic [RSP_WIDTH-1:0]      pipe_out;
  logic                      pipe_empty, pipe_full;
  logic                      unused_addr;

  // Ready depends on credits only.  It stalls writes as well as reads, so a
  // write can never overtake a read that is waiting at the port.
  assign mem_req_ready = (credits_q < CRED_MAX);
  assign busy          = (credits_q != '0);

  assign req_fire = mem_req_valid && mem_req_ready;
  assign rd_fire  = req_fire && !mem_req_rw;
  assign wr_fire  = req_fire &&  mem_req_rw;
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

  // Upper line-address bits are dropped, so addresses alias modulo RAM_DEPTH
  assign ram_idx     = mem_req_addr[RAM_ADDR_WIDTH-1:0];
  assign unused_addr = ^mem_req_addr;

  // RAM: byte-enabled write at the accept edge, no reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) ram_q[ram_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Read in the accept cycle, so a write accepted one cycle earlier is visible
  assign rd_data = ram_q[ram_idx];

  // Outstanding-read credits
  always_comb begin
    credits_d = credits_q;
    case ({rd_fire, rsp_fire})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) credits_q <= '0;
    else       credits_q <= credits_d;
  end

  vx_mem_rsp_pipe #(
    .WIDTH   (RSP_WIDTH),
    .LATENCY (LATENCY),
    .DEPTH   (RSPQ_SIZE)
  ) u_rsp_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (rd_fire),
    .in_data_i   ({rd_data, mem_req_tag}),
    .out_valid_o (mem_rsp_valid),
    .out_data_o  (pipe_out),
    .out_ready_i (mem_rsp_ready),
    .empty_o     (pipe_empty),
    .full_o      (pipe_full)
  );

  assign {mem_rsp_data, mem_rsp_tag} = pipe_out;

  // Credits bound everything in flight.  A full FIFO therefore means
  // saturated credits, and zero credits means an empty FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rd_fire && !rsp_fire && credits_q == CRED_MAX))
        else $error("vx_mem_responder: credit overflow");
      assert (!(rsp_fire && !rd_fire && credits_q == '0))
        else $error("vx_mem_responder: credit underflow");
      assert (!pipe_full || credits_q == CRED_MAX)
        else $error("vx_mem_responder: FIFO full without full credits");
      assert (busy || pipe_empty)
        else $error("vx_mem_responder: FIFO holds data while idle");
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
module tb_vx_mem_responder;

  localparam int DW  = 64;
  localparam int AW  = 16;
  localparam int TW  = 8;
  localparam int RAW = 10;
  localparam int LAT = 4;
  localparam int QS  = 8;

  logic          clk;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  vx_mem_responder #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TAG_WIDTH      (TW),
    .RAM_ADDR_WIDTH (RAW),
    .LATENCY        (LAT),
    .RSPQ_SIZE      (QS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request at a negedge; it is taken at the following posedge.
  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] be, input logic [TW-1:0] tag);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    mem_req_tag    = tag;
    @(negedge clk);
  endtask

  task automatic idle_req();
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
  endtask

  // Called one negedge after a read accept; counts cycles until valid shows.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!mem_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_acc;
    int n_pop;
    int seen;

    reset          = 1'b1;
    mem_rsp_ready  = 1'b1;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    idle_req();

    // Reset behaviour
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", mem_rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", mem_req_ready, 1);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_rsp_valid", mem_rsp_valid, 0);

    // Full write then read of the same line in the next cycle
    issue(1'b1, 16'h0010, {8{8'hA5}}, 8'hFF, 8'h00);
    issue(1'b0, 16'h0010, '0, 8'h00, 8'h03);
    idle_req();
    check_eq("busy_rd_inflight", busy, 1);
    wait_rsp(lat);
    check_eq("t1_latency", lat, LAT);
    check_eq("t1_data", mem_rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check_eq("t1_tag", mem_rsp_tag, 8'h03);
    @(negedge clk);
    check_eq("t1_rsp_popped", mem_rsp_valid, 0);
    check_eq("t1_busy_clear", busy, 0);

    // Partial write: only byte 0 is enabled
    issue(1'b1, 16'h0020, '0, 8'hFF, 8'h00);
    issue(1'b1, 16'h0020, {DW{1'b1}}, 8'h01, 8'h00);
    issue(1'b0, 16'h0020, '0, 8'h00, 8'h05);
    idle_req();
    wait_rsp(lat);
    check_eq("t2_latency", lat, LAT);
    check_eq("t2_data", mem_rsp_data, 64'h0000_0000_0000_00FF);
    check_eq("t2_tag", mem_rsp_tag, 8'h05);
    @(negedge clk);

    // Aliasing: 0x400 and 0x000 map to the same RAM line
    issue(1'b1, 16'h0400, 64'h0123_4567_89AB_CDEF, 8'hFF, 8'h00);
    issue(1'b0, 16'h0000, '0, 8'h00, 8'h07);
    idle_req();
    wait_rsp(lat);
    check_eq("t3_latency", lat, LAT);
    check_eq("t3_data", mem_rsp_data, 64'h0123_4567_89AB_CDEF);
    check_eq("t3_tag", mem_rsp_tag, 8'h07);
    @(negedge clk);

    // Backpressure: 10 reads against a stalled consumer
    mem_rsp_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 5 || c == 13) begin
        check_eq($sformatf("stall_valid_c%0d", c), mem_rsp_valid, 1);
        check_eq($sformatf("stall_tag_c%0d", c), mem_rsp_tag, 8'h00);
      end
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = AW'(n_acc);
      mem_req_tag   = TW'(n_acc);
      if (mem_req_ready) n_acc++;
      @(negedge clk);
    end
    check_eq("bp_accepts", n_acc, QS);
    check_eq("bp_ready_low", mem_req_ready, 0);
    check_eq("bp_busy", busy, 1);
    check_eq("bp_rsp_valid", mem_rsp_valid, 1);
    check_eq("bp_head_tag", mem_rsp_tag, 8'h00);
    check_eq("bp_head_data", mem_rsp_data, 64'h0123_4567_89AB_CDEF);

    // Release: drain in order while tags 8 and 9 get in behind
    mem_rsp_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 40 && n_pop < 10; c++) begin
      if (c == 0) check_eq("full_ready_before_pop", mem_req_ready, 0);
      if (c == 1) check_eq("ready_after_first_pop", mem_req_ready, 1);
      if (c == 2) check_eq("ready_accept_and_pop", mem_req_ready, 1);
      if (c == 3) check_eq("b2b_accepts", n_acc, 10);
      mem_req_valid = (n_acc < 10);
      mem_req_rw    = 1'b0;
      mem_req_addr  = AW'(n_acc);
      mem_req_tag   = TW'(n_acc);
      if (mem_req_valid && mem_req_ready) n_acc++;
      if (mem_rsp_valid) begin
        check_eq($sformatf("order_%0d", n_pop), mem_rsp_tag, TW'(n_pop));
        n_pop++;
      end
      @(negedge clk);
    end
    idle_req();
    check_eq("drain_count", n_pop, 10);
    @(negedge clk);
    check_eq("drain_busy", busy, 0);
    check_eq("drain_ready", mem_req_ready, 1);

    // Reset with three reads in flight
    issue(1'b0, 16'h0001, '0, 8'h00, 8'h21);
    issue(1'b0, 16'h0002, '0, 8'h00, 8'h22);
    issue(1'b0, 16'h0003, '0, 8'h00, 8'h23);
    idle_req();
    check_eq("inflight_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rsp_valid", mem_rsp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", mem_req_ready, 1);
    check_eq("mid_rst_busy", busy, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_rsp_valid) seen++;
      @(negedge clk);
    end
    check_eq("no_rsp_after_reset", seen, 0);
    check_eq("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
